// File: rtl/var_shift_tx.sv
// var_shift_tx: serialises one 32-bit word into variable-width chunks, LSB- or MSB-first.
// Latency: first chunk is valid 1 cycle after the word is accepted; back-to-back words have no bubble.
// Backpressure: chunk outputs hold while out_ready=0 or en=0; in_ready is low until the last chunk transfers.
// Optional: define VAR_SHIFT_TX_PARITY_EN to add the out_parity output (even parity of the valid chunk bits).
module var_shift_tx #(
  parameter int DW = 32,
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          en,
  input  logic          dir,
  input  logic [CW-1:0] width,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic [CW-1:0] out_bits,
  output logic          out_last,
  output logic          out_valid,
`ifdef VAR_SHIFT_TX_PARITY_EN
  output logic          out_parity,
`endif
  input  logic          out_ready
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  localparam logic [CW-1:0] FULL = CW'(DW);

  state_t        state_q, state_d;
  logic [DW-1:0] data_q;     // word being shifted out
  logic [CW-1:0] rem;        // bits of the word not yet transferred
  logic [CW-1:0] w_q;        // chunk width captured at load (1..32)
  logic          dir_q;      // shift direction captured at load

  logic          load;
  logic          xfer;
  logic          last_c;
  logic [CW-1:0] n;
  logic [DW-1:0] mask;
  logic [DW-1:0] chunk;

  // Chunk size is the captured width, clipped to what is left of the word.
  always_comb begin
    n      = (w_q < rem) ? w_q : rem;
    last_c = (rem <= w_q);
    mask   = (n >= FULL) ? {DW{1'b1}} : ((DW'(1) << n) - DW'(1));
    chunk  = dir_q ? (data_q >> (FULL - n)) : (data_q & mask);
  end

  assign out_valid = (state_q == SEND);
  assign xfer      = out_valid & out_ready & en;
  assign in_ready  = en & ((state_q == IDLE) | (xfer & last_c));
  assign load      = in_valid & in_ready;

  // Chunk outputs come straight from registers and are forced to zero when nothing is held.
  assign out_data = out_valid ? chunk : '0;
  assign out_bits = out_valid ? n : '0;
  assign out_last = out_valid & last_c;

`ifdef VAR_SHIFT_TX_PARITY_EN
  // Upper bits of out_data are zero, so a full reduction gives parity of the n valid bits.
  assign out_parity = ^out_data;
`endif

  // State register; reset drops any word in flight.
  always_ff @(posedge clk) begin
    if (!clr) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state: a load always wins (it is the no-bubble follow-on), otherwise go idle after the last chunk.
  always_comb begin
    state_d = state_q;
    if (load)                 state_d = SEND;
    else if (xfer && last_c)  state_d = IDLE;
  end

  // Datapath: capture word and settings at load, shift out one chunk per transfer.
  always_ff @(posedge clk) begin
    if (!clr) begin
      data_q <= '0;
      rem    <= '0;
      w_q    <= '0;
      dir_q  <= 1'b0;
    end else if (load) begin
      data_q <= in_data;
      rem    <= FULL;
      w_q    <= (width == '0) ? FULL : width;
      dir_q  <= dir;
    end else if (xfer) begin
      data_q <= dir_q ? (data_q << n) : (data_q >> n);
      rem    <= rem - n;
    end
  end

endmodule

// File: doc/var_shift_tx.md
Name: var_shift_tx

Overview:
- Transmit-side partner to the variable-shift receive register: takes one 32-bit parallel word and emits it as a sequence of variable-width chunks.
- The receive register reassembles those chunks by shifting them in.
- Chunk width and shift direction are captured per word.
- Ready/valid handshake on both the input word and the output chunk stream.

Parameters:
- DW, 32, data word width (fixed at 32 for this revision)
- CW, 6, width of chunk-size and bit-count fields (log2(DW)+1)

Ports:
- clk  in  1  clock, rising edge
- clr  in  1  reset, synchronous, active-low
- en  in  1  global advance enable; low freezes all state
- dir  in  1  0 = right / LSB-first, 1 = left / MSB-first; sampled at load
- width  in  6  chunk size 1..32, 0 means 32; sampled at load
- in_data  in  32  parallel word to send
- in_valid  in  1  in_data valid
- in_ready  out  1  block can accept a word this cycle
- out_data  out  32  current chunk, right-aligned, upper bits zero
- out_bits  out  6  number of valid bits in out_data (1..32)
- out_last  out  1  current chunk is the final chunk of the word
- out_valid  out  1  chunk valid
- out_ready  in  1  downstream accepts chunk

Behaviour:
- Reset, when clr = 0 at a clk edge:
  - state = IDLE; buf, rem, w_q, dir_q = 0; out_valid = 0.
  - out_data, out_bits and out_last read 0.
  - An in-flight word is discarded.
- States:
  - IDLE: no word held.
  - SEND: word held, out_valid = 1.
- Transfer definitions:
  - load = in_valid & in_ready.
  - xfer = out_valid & out_ready & en.
- in_ready = en & (state == IDLE | (xfer & out_last)).
  - This is the only combinational input-to-output path (from out_ready and en).
- Load action:
  - buf <= in_data; rem <= 32; dir_q <= dir.
  - w_q <= (width == 0) ? 32 : width.
  - Next state is SEND, so out_valid = 1 on the following cycle.
  - Load-to-first-chunk latency is 1 cycle.
- Chunk size: n = min(w_q, rem). out_bits = n. out_last = (rem <= w_q).
- dir_q = 0 (LSB-first):
  - out_data = buf[n-1:0], zero-extended.
  - On xfer, buf <= buf >> n.
- dir_q = 1 (MSB-first):
  - out_data = buf[31:32-n], right-aligned.
  - On xfer, buf <= buf << n.
- On xfer, rem <= rem - n.
  - If out_last and no load that cycle: state goes to IDLE and out_valid goes to 0.
  - If out_last and load in the same cycle: the new word is taken with no bubble, and out_valid stays 1.
- Holding rules:
  - out_data, out_bits and out_last are stable while out_valid = 1 and there is no xfer.
  - out_valid never drops without a transfer, except on reset.
- width and dir changes while in SEND are ignored until the next load.
- en = 0: no load, no xfer, and all registers hold. out_valid keeps its current value.
- Partial final chunk: when 32 is not a multiple of w_q, the last chunk carries rem bits and out_bits = rem.
- rem never underflows. rem = 0 occurs only in IDLE.
- Outputs other than in_ready are decoded from registers only.

Optional Feature:
- Macro VAR_SHIFT_TX_PARITY_EN.
- Defined: adds output port out_parity (1 bit).
  - out_parity = XOR of the n valid bits of out_data (even parity), under the same stability rules as out_data.
  - Reads 0 in reset and in IDLE.
- Undefined: port absent; no parity logic.

Test Plan:
- LSB-first, width 8: load 0xDEADBEEF, width = 8, dir = 0, out_ready = 1 → chunks 0xEF, 0xBE, 0xAD, 0xDE; out_bits = 8 each; out_last only on 0xDE; in_ready = 1 on that cycle.
- MSB-first, width 8: same word, dir = 1 → chunks 0xDE, 0xAD, 0xBE, 0xEF.
- Partial final chunk: load 0x12345678, width = 12, dir = 0 → 0x678 (12 bits), 0x345 (12 bits), 0x12 (8 bits, out_last = 1).
  - Same word with dir = 1 → 0x123, 0x456, 0x78 (8 bits, out_last = 1).
- width = 0: one chunk, out_data = in_data, out_bits = 32, out_last = 1.
- Back-to-back and backpressure:
  - in_valid held with two words, out_ready = 1: second word loads on the last-chunk cycle with no idle cycle between words.
  - out_ready = 0 for 4 cycles mid-word: outputs are unchanged.
  - en = 0 for 3 cycles mid-word: no advance, and in_ready = 0.
- Reset mid-word: clr = 0 after the 2nd chunk → out_valid = 0 next cycle; in_ready = 1 once clr = 1 and en = 1; the next word starts fresh.
- Parity, with VAR_SHIFT_TX_PARITY_EN defined: first case gives out_parity = 1, 0, 1, 0 for 0xEF, 0xBE, 0xAD, 0xDE.
